// File: rtl/wb_queue_pkg.sv
// Shared constants for the write-back path. DataWidth and RegNumWidth match
// the integer register file so both blocks agree on the write-port shape.
package wb_queue_pkg;

  localparam int unsigned DataWidth    = 32;
  localparam int unsigned RegNumWidth  = 5;
  localparam int unsigned DefaultDepth = 4;

endpackage : wb_queue_pkg

// File: rtl/wb_fwd_match.sv
// Youngest-match forwarding lookup over the write-back queue entries.
// Ports:
//   ent_rd_i / ent_data_i : entry storage (destination index, data)
//   ent_vld_i             : per-entry occupied mask
//   head_i                : index of the oldest entry
//   num_i                 : register index to look up (0 never hits)
//   hit_o / data_o        : match found / data of youngest match (0 on miss)
module wb_fwd_match
  import wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH         = DefaultDepth,
  parameter int unsigned DATA_WIDTH    = DataWidth,
  parameter int unsigned REG_NUM_WIDTH = RegNumWidth,
  localparam int unsigned PtrWidth     = $clog2(DEPTH)
) (
  input  logic [REG_NUM_WIDTH-1:0] ent_rd_i   [DEPTH],
  input  logic [DATA_WIDTH-1:0]    ent_data_i [DEPTH],
  input  logic [DEPTH-1:0]         ent_vld_i,
  input  logic [PtrWidth-1:0]      head_i,
  input  logic [REG_NUM_WIDTH-1:0] num_i,
  output logic                     hit_o,
  output logic [DATA_WIDTH-1:0]    data_o
);

  logic [PtrWidth-1:0] idx;

  // Scan oldest to youngest; a later match overrides, so the youngest wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_i + PtrWidth'(i);
      if (ent_vld_i[idx] && (ent_rd_i[idx] == num_i) && (num_i != '0)) begin
        hit_o  = 1'b1;
        data_o = ent_data_i[idx];
      end
    end
  end

endmodule : wb_fwd_match

// File: rtl/wb_queue.sv
// In-order write-back queue between the ALU / load unit and the register
// file's single write port, with two forwarding lookup ports.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   ld_valid/ld_rd/ld_data/ld_ready     : load result handshake (older)
//   alu_valid/alu_rd/alu_data/alu_ready : ALU result handshake (younger)
//   wr_en/wr_num/wr_data          : register-file write, driven from the head
//   fwd_num*/fwd_hit*/fwd_data*   : forwarding lookups over pending writes
//   count                         : occupied entries
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH         = DefaultDepth,
  parameter int unsigned DATA_WIDTH    = DataWidth,
  parameter int unsigned REG_NUM_WIDTH = RegNumWidth,
  localparam int unsigned PtrWidth     = $clog2(DEPTH),
  localparam int unsigned CntWidth     = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld_valid,
  input  logic [REG_NUM_WIDTH-1:0] ld_rd,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  output logic                     ld_ready,
  input  logic                     alu_valid,
  input  logic [REG_NUM_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  output logic                     alu_ready,
  output logic                     wr_en,
  output logic [REG_NUM_WIDTH-1:0] wr_num,
  output logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [REG_NUM_WIDTH-1:0] fwd_num0,
  input  logic [REG_NUM_WIDTH-1:0] fwd_num1,
  output logic                     fwd_hit0,
  output logic                     fwd_hit1,
  output logic [DATA_WIDTH-1:0]    fwd_data0,
  output logic [DATA_WIDTH-1:0]    fwd_data1,
  output logic [CntWidth-1:0]      count
);

  logic [PtrWidth-1:0]      head_q, head_d, tail_q, tail_d, alu_slot_c;
  logic [CntWidth-1:0]      count_q, count_d;
  logic [DEPTH-1:0]         vld_q, vld_d;
  logic [REG_NUM_WIDTH-1:0] rd_q   [DEPTH];
  logic [REG_NUM_WIDTH-1:0] rd_d   [DEPTH];
  logic [DATA_WIDTH-1:0]    data_q [DEPTH];
  logic [DATA_WIDTH-1:0]    data_d [DEPTH];
  logic                     ld_push_c, alu_push_c, pop_c;

  // Readiness looks at count only; a same-cycle drain earns no credit.
  assign ld_ready  = !reset && (count_q < CntWidth'(DEPTH));
  assign alu_ready = !reset && ((count_q < CntWidth'(DEPTH - 1)) ||
                     ((count_q == CntWidth'(DEPTH - 1)) && !(ld_valid && (ld_rd != '0))));

  // Writes to x0 complete the handshake but are dropped here.
  assign ld_push_c  = ld_valid && ld_ready && (ld_rd != '0);
  assign alu_push_c = alu_valid && alu_ready && (alu_rd != '0);
  assign pop_c      = (count_q != '0);

  // The load is older, so it takes the tail slot and the ALU result follows.
  assign alu_slot_c = tail_q + PtrWidth'(ld_push_c);

  assign wr_en   = pop_c;
  assign wr_num  = pop_c ? rd_q[head_q]   : '0;
  assign wr_data = pop_c ? data_q[head_q] : '0;
  assign count   = count_q;

  // Next-state for pointers, occupancy and entry payloads.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q + PtrWidth'(ld_push_c) + PtrWidth'(alu_push_c);
    count_d = count_q + CntWidth'(ld_push_c) + CntWidth'(alu_push_c) - CntWidth'(pop_c);
    vld_d   = vld_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (pop_c) begin
      head_d        = head_q + PtrWidth'(1);
      vld_d[head_q] = 1'b0;
    end
    if (ld_push_c) begin
      vld_d[tail_q]  = 1'b1;
      rd_d[tail_q]   = ld_rd;
      data_d[tail_q] = ld_data;
    end
    if (alu_push_c) begin
      vld_d[alu_slot_c]  = 1'b1;
      rd_d[alu_slot_c]   = alu_rd;
      data_d[alu_slot_c] = alu_data;
    end
  end

  // Control state; reset discards every pending entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  // Payload storage; contents are only observed through the valid mask.
  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

  wb_fwd_match #(
    .DEPTH        (DEPTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .REG_NUM_WIDTH(REG_NUM_WIDTH)
  ) u_fwd0 (
    .ent_rd_i  (rd_q),
    .ent_data_i(data_q),
    .ent_vld_i (vld_q),
    .head_i    (head_q),
    .num_i     (fwd_num0),
    .hit_o     (fwd_hit0),
    .data_o    (fwd_data0)
  );

  wb_fwd_match #(
    .DEPTH        (DEPTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .REG_NUM_WIDTH(REG_NUM_WIDTH)
  ) u_fwd1 (
    .ent_rd_i  (rd_q),
    .ent_data_i(data_q),
    .ent_vld_i (vld_q),
    .head_i    (head_q),
    .num_i     (fwd_num1),
    .hit_o     (fwd_hit1),
    .data_o    (fwd_data1)
  );

endmodule : wb_queue

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: a DEPTH=4 instance for the main behaviour and
// a DEPTH=2 instance, where a completely full queue is reachable.
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid, alu_valid, ld_ready, alu_ready, wr_en;
  logic [4:0]  ld_rd, alu_rd, wr_num, fwd_num0, fwd_num1;
  logic [31:0] ld_data, alu_data, wr_data, fwd_data0, fwd_data1;
  logic        fwd_hit0, fwd_hit1;
  logic [2:0]  count;

  logic        d2_ld_valid, d2_alu_valid, d2_ld_ready, d2_alu_ready, d2_wr_en;
  logic [4:0]  d2_ld_rd, d2_alu_rd, d2_wr_num;
  logic [31:0] d2_ld_data, d2_alu_data, d2_wr_data, d2_fwd_data0, d2_fwd_data1;
  logic        d2_fwd_hit0, d2_fwd_hit1;
  logic [1:0]  d2_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(4)) u_dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
    .fwd_num0(fwd_num0), .fwd_num1(fwd_num1),
    .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1),
    .fwd_data0(fwd_data0), .fwd_data1(fwd_data1),
    .count(count)
  );

  wb_queue #(.DEPTH(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .ld_valid(d2_ld_valid), .ld_rd(d2_ld_rd), .ld_data(d2_ld_data), .ld_ready(d2_ld_ready),
    .alu_valid(d2_alu_valid), .alu_rd(d2_alu_rd), .alu_data(d2_alu_data), .alu_ready(d2_alu_ready),
    .wr_en(d2_wr_en), .wr_num(d2_wr_num), .wr_data(d2_wr_data),
    .fwd_num0(5'd1), .fwd_num1(5'd2),
    .fwd_hit0(d2_fwd_hit0), .fwd_hit1(d2_fwd_hit1),
    .fwd_data0(d2_fwd_data0), .fwd_data1(d2_fwd_data1),
    .count(d2_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance through one posedge to just after the following negedge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
  endtask

  logic [36:0] q[$];
  logic [36:0] head_e;
  logic        e_ldr, e_alur;

  initial begin
    reset = 1'b1;
    idle();
    fwd_num0 = 5'd5; fwd_num1 = 5'd0;
    d2_ld_valid = 1'b0; d2_ld_rd = '0; d2_ld_data = '0;
    d2_alu_valid = 1'b0; d2_alu_rd = '0; d2_alu_data = '0;
    repeat (2) @(negedge clk);
    ld_valid = 1'b1; ld_rd = 5'd5; alu_valid = 1'b1; alu_rd = 5'd6;
    #1;
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_num", wr_num, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_fwd_hit", fwd_hit0, 0);
    chk("rst_fwd_data", fwd_data0, 0);
    chk("rst_d2_count", d2_count, 0);

    // Single write
    reset = 1'b0; idle();
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'hDEADBEEF;
    #1 chk("single_ld_ready", ld_ready, 1);
    cyc(); idle(); #1;
    chk("single_wr_en", wr_en, 1);
    chk("single_wr_num", wr_num, 5);
    chk("single_wr_data", wr_data, 32'hDEADBEEF);
    chk("single_count", count, 1);
    chk("single_fwd_hit", fwd_hit0, 1);
    chk("single_fwd_data", fwd_data0, 32'hDEADBEEF);
    cyc();
    chk("single_drained_count", count, 0);
    chk("single_drained_wr_en", wr_en, 0);
    chk("single_drained_fwd_hit", fwd_hit0, 0);
    chk("single_drained_fwd_data", fwd_data0, 0);

    // Dual push ordering
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h22;
    #1 chk("dual_alu_ready", alu_ready, 1);
    cyc(); idle(); fwd_num0 = 5'd3; fwd_num1 = 5'd7; #1;
    chk("dual_count", count, 2);
    chk("dual_fwd_youngest", fwd_data0, 32'h22);
    chk("dual_fwd_miss", fwd_hit1, 0);
    chk("dual_first_wr", wr_data, 32'h11);
    cyc();
    chk("dual_second_wr", wr_data, 32'h22);
    chk("dual_second_count", count, 1);
    cyc();
    chk("dual_done_count", count, 0);

    // Writes to x0 are accepted and dropped
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    #1 chk("x0_alu_ready", alu_ready, 1);
    cyc(); idle(); fwd_num0 = 5'd0; #1;
    chk("x0_count", count, 0);
    chk("x0_wr_en", wr_en, 0);
    chk("x0_fwd_hit", fwd_hit0, 0);

    // Fill toward capacity and back-pressure on the ALU port
    ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'hA1;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'hA2;
    cyc();
    ld_rd = 5'd3; ld_data = 32'hA3; alu_rd = 5'd4; alu_data = 32'hA4;
    #1;
    chk("fill_c2_alu_ready", alu_ready, 1);
    chk("fill_c2_wr_num", wr_num, 1);
    cyc(); idle(); #1;
    chk("fill_count3", count, 3);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hA7;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'hA8;
    #1;
    chk("fill_c3_ld_ready", ld_ready, 1);
    chk("fill_c3_alu_ready", alu_ready, 0);
    chk("fill_c3_wr_num", wr_num, 2);
    cyc();
    ld_rd = 5'd0;
    #1;
    chk("fill_c3_x0ld_alu_ready", alu_ready, 1);
    chk("fill_c3_count", count, 3);
    chk("fill_c3b_wr_num", wr_num, 3);
    cyc(); idle(); fwd_num1 = 5'd8; #1;
    chk("fill_hold_count", count, 3);
    chk("fill_drain_4", wr_num, 4);
    chk("fill_fwd_a8", fwd_data1, 32'hA8);
    cyc();
    chk("fill_drain_7", wr_num, 7);
    cyc();
    chk("fill_drain_8", wr_num, 8);
    chk("fill_drain_count", count, 1);
    cyc();
    chk("fill_empty", count, 0);

    // Completely full on the DEPTH=2 instance
    d2_ld_valid = 1'b1; d2_ld_rd = 5'd1; d2_ld_data = 32'hB1;
    d2_alu_valid = 1'b1; d2_alu_rd = 5'd2; d2_alu_data = 32'hB2;
    #1 chk("d2_alu_ready_empty", d2_alu_ready, 1);
    cyc();
    chk("d2_full_count", d2_count, 2);
    chk("d2_full_ld_ready", d2_ld_ready, 0);
    chk("d2_full_alu_ready", d2_alu_ready, 0);
    chk("d2_full_wr_num", d2_wr_num, 1);
    cyc();
    chk("d2_after_count", d2_count, 1);
    chk("d2_after_wr_num", d2_wr_num, 2);
    d2_ld_valid = 1'b0; d2_alu_valid = 1'b0;
    cyc();
    chk("d2_empty_count", d2_count, 0);

    // Sustained dual offers across pointer wrap, against a reference queue
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1'b1; ld_rd = 5'(i + 1); ld_data = 32'h100 + 32'(i);
      alu_valid = 1'b1; alu_rd = 5'(i + 11); alu_data = 32'h200 + 32'(i);
      #1;
      e_ldr  = (q.size() < 4);
      e_alur = (q.size() < 3);
      head_e = (q.size() != 0) ? q[0] : 37'd0;
      chk("wrap_ld_ready", ld_ready, e_ldr);
      chk("wrap_alu_ready", alu_ready, e_alur);
      chk("wrap_wr_en", wr_en, q.size() != 0);
      chk("wrap_wr", {wr_num, wr_data}, head_e);
      if (q.size() != 0) void'(q.pop_front());
      if (e_ldr) q.push_back({ld_rd, ld_data});
      if (e_alur) q.push_back({alu_rd, alu_data});
      cyc();
    end
    idle();
    while (q.size() != 0) begin
      #1 chk("wrap_tail_wr", {wr_num, wr_data}, q[0]);
      void'(q.pop_front());
      cyc();
    end
    chk("wrap_empty", count, 0);

    // Reset in mid-stream
    ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'hC0;
    alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'hC1;
    cyc();
    ld_rd = 5'd22; alu_rd = 5'd23;
    cyc(); idle(); #1;
    chk("rstmid_count3", count, 3);
    reset = 1'b1;
    ld_valid = 1'b1; ld_rd = 5'd24; alu_valid = 1'b1; alu_rd = 5'd25;
    #1;
    chk("rstmid_ld_ready", ld_ready, 0);
    chk("rstmid_alu_ready", alu_ready, 0);
    cyc(); reset = 1'b0; idle(); #1;
    chk("rstmid_count", count, 0);
    chk("rstmid_wr_en", wr_en, 0);
    chk("rstmid_ld_ready_after", ld_ready, 1);
    chk("rstmid_alu_ready_after", alu_ready, 1);
    cyc();
    chk("rstmid_no_stale", wr_en, 0);

    // Forwarding aging: in-flight enqueue invisible, then youngest, then miss
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h1;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h3;
    cyc();
    alu_valid = 1'b0; ld_data = 32'h2; fwd_num0 = 5'd9;
    #1;
    chk("age_enq_invisible", fwd_data0, 32'h1);
    chk("age_head_wr_num", wr_num, 9);
    cyc(); idle(); #1;
    chk("age_youngest", fwd_data0, 32'h2);
    chk("age_count", count, 2);
    cyc(); cyc();
    chk("age_count_empty", count, 0);
    chk("age_miss_hit", fwd_hit0, 0);
    chk("age_miss_data", fwd_data0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_wb_queue
